// File: rtl/reg_status_table.sv
// Register status table: per-register pending bit and producer tag, with CDB wakeup.
// Optional macro RST_CDB_BYPASS_EN makes same-cycle CDB matches appear non-pending on lookups.
module reg_status_table #(
  parameter int W_ADDR = 5,
  parameter int W_TAG  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   dispatch_rd_en,
  input  logic [W_ADDR-1:0]      dispatch_rd_addr,
  input  logic [W_TAG-1:0]       dispatch_rd_tag,
  input  logic [W_ADDR-1:0]      dispatch_rsaddr,
  input  logic [W_ADDR-1:0]      dispatch_rtaddr,
  output logic                   rst_rs_pending,
  output logic                   rst_rt_pending,
  output logic [W_TAG-1:0]       rst_rs_tag,
  output logic [W_TAG-1:0]       rst_rt_tag,
  input  logic                   cdb_valid,
  input  logic [W_TAG-1:0]       cdb_tag,
  output logic [(1<<W_ADDR)-1:0] rst_wen_onehot
);
  localparam int DEPTH = 1 << W_ADDR;

  logic [DEPTH-1:0]            pend_q, pend_d;
  logic [DEPTH-1:0][W_TAG-1:0] tag_q, tag_d;
  logic [DEPTH-1:0]            match;
  logic                        disp_ok;

  assign disp_ok = dispatch_rd_en && (dispatch_rd_addr != '0);

  always_comb begin
    match = '0;
    for (int i = 1; i < DEPTH; i++)
      match[i] = cdb_valid && pend_q[i] && (tag_q[i] == cdb_tag);
  end

  assign rst_wen_onehot = match;

  // CDB clears first so a same-cycle dispatch to the matched entry wins.
  always_comb begin
    pend_d = pend_q & ~match;
    tag_d  = tag_q;
    if (flush) begin
      pend_d = '0;
    end else if (disp_ok) begin
      pend_d[dispatch_rd_addr] = 1'b1;
      tag_d[dispatch_rd_addr]  = dispatch_rd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      tag_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tag_q  <= tag_d;
    end
  end

  logic rs_hide, rt_hide;
`ifdef RST_CDB_BYPASS_EN
  assign rs_hide = match[dispatch_rsaddr] && !(disp_ok && dispatch_rd_addr == dispatch_rsaddr);
  assign rt_hide = match[dispatch_rtaddr] && !(disp_ok && dispatch_rd_addr == dispatch_rtaddr);
`else
  assign rs_hide = 1'b0;
  assign rt_hide = 1'b0;
`endif

  always_comb begin
    rst_rs_pending = pend_q[dispatch_rsaddr] && !rs_hide;
    rst_rt_pending = pend_q[dispatch_rtaddr] && !rt_hide;
    rst_rs_tag     = rst_rs_pending ? tag_q[dispatch_rsaddr] : '0;
    rst_rt_tag     = rst_rt_pending ? tag_q[dispatch_rtaddr] : '0;
  end
endmodule

// File: tb/tb_reg_status_table.sv
// Self-checking bench for reg_status_table: directed scenarios plus random traffic vs. a table model.
module tb_reg_status_table;
  logic        clk = 0;
  logic        reset, flush, dispatch_rd_en, cdb_valid;
  logic [4:0]  dispatch_rd_addr, dispatch_rsaddr, dispatch_rtaddr;
  logic [5:0]  dispatch_rd_tag, cdb_tag;
  logic        rst_rs_pending, rst_rt_pending;
  logic [5:0]  rst_rs_tag, rst_rt_tag;
  logic [31:0] rst_wen_onehot;

  int n_cmp = 0, n_bad = 0;

  reg_status_table #(.W_ADDR(5), .W_TAG(6)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_rd_en(dispatch_rd_en), .dispatch_rd_addr(dispatch_rd_addr),
    .dispatch_rd_tag(dispatch_rd_tag), .dispatch_rsaddr(dispatch_rsaddr),
    .dispatch_rtaddr(dispatch_rtaddr), .rst_rs_pending(rst_rs_pending),
    .rst_rt_pending(rst_rt_pending), .rst_rs_tag(rst_rs_tag), .rst_rt_tag(rst_rt_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .rst_wen_onehot(rst_wen_onehot));

  always #5 clk = ~clk;

  // Reference table: what each architectural register is waiting on.
  bit       m_pend[32];
  bit [5:0] m_tag[32];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit hit(int i);
    return cdb_valid && m_pend[i] && m_tag[i] == cdb_tag;
  endfunction

  function automatic bit vis_pend(int a);
    bit p = m_pend[a];
`ifdef RST_CDB_BYPASS_EN
    if (hit(a) && !(dispatch_rd_en && dispatch_rd_addr == a && a != 0)) p = 0;
`endif
    return p;
  endfunction

  task automatic check_model();
    logic [31:0] w = '0;
    bit pr, pt;
    for (int i = 0; i < 32; i++) w[i] = hit(i);
    pr = vis_pend(int'(dispatch_rsaddr));
    pt = vis_pend(int'(dispatch_rtaddr));
    chk("wen", rst_wen_onehot, w);
    chk("rs_pend", rst_rs_pending, pr);
    chk("rt_pend", rst_rt_pending, pt);
    chk("rs_tag", rst_rs_tag, pr ? m_tag[dispatch_rsaddr] : 6'd0);
    chk("rt_tag", rst_rt_tag, pt ? m_tag[dispatch_rtaddr] : 6'd0);
  endtask

  task automatic apply(bit rst, bit fl, bit en, int rd, int tg, int rs, int rt, bit cv, int ct);
    @(negedge clk);
    reset = rst; flush = fl; dispatch_rd_en = en;
    dispatch_rd_addr = 5'(rd); dispatch_rd_tag = 6'(tg);
    dispatch_rsaddr = 5'(rs); dispatch_rtaddr = 5'(rt);
    cdb_valid = cv; cdb_tag = 6'(ct);
    #1 check_model();
  endtask

  task automatic tick();
    bit h[32];
    @(posedge clk);
    for (int i = 0; i < 32; i++) h[i] = hit(i);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_tag[i] = 0; end
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < 32; i++) if (h[i]) m_pend[i] = 0;
      if (dispatch_rd_en && dispatch_rd_addr != 0) begin
        m_pend[dispatch_rd_addr] = 1;
        m_tag[dispatch_rd_addr]  = dispatch_rd_tag;
      end
    end
  endtask

  task automatic idle(int rs, int rt);
    apply(0, 0, 0, 0, 0, rs, rt, 0, 0);
  endtask

  initial begin
    reset = 1; flush = 0; dispatch_rd_en = 0; dispatch_rd_addr = 0; dispatch_rd_tag = 0;
    dispatch_rsaddr = 0; dispatch_rtaddr = 0; cdb_valid = 0; cdb_tag = 0;
    @(posedge clk); tick();
    for (int i = 0; i < 32; i++) begin m_pend[i] = 0; m_tag[i] = 0; end

    // Reset state
    idle(5, 9);
    chk("rst_rs_pend", rst_rs_pending, 0);
    chk("rst_wen", rst_wen_onehot, 0);
    tick();

    // Dispatch then lookup
    apply(0, 0, 1, 5, 'h11, 5, 0, 0, 0);
    chk("nobypass_pend", rst_rs_pending, 0);
    tick();
    idle(5, 0);
    chk("r29_pend", rst_rs_pending, 1);
    chk("r29_tag", rst_rs_tag, 'h11);
    chk("r29_wen", rst_wen_onehot, 0);
    tick();

    // CDB wakeup and bypass visibility
    apply(0, 0, 0, 0, 0, 5, 5, 1, 'h11);
    chk("r30_wen", rst_wen_onehot, 32'h20);
`ifdef RST_CDB_BYPASS_EN
    chk("r30_byp", rst_rs_pending, 0);
`else
    chk("r30_byp", rst_rs_pending, 1);
`endif
    tick();
    idle(5, 5);
    chk("r30_clr", rst_rs_pending, 0);
    tick();

    // Dispatch collides with CDB on the same entry
    apply(0, 0, 1, 7, 'h03, 0, 0, 0, 0); tick();
    apply(0, 0, 1, 7, 'h04, 7, 7, 1, 'h03);
    chk("r31_wen", rst_wen_onehot, 32'h80);
    tick();
    idle(7, 7);
    chk("r31_pend", rst_rs_pending, 1);
    chk("r31_tag", rst_rs_tag, 'h04);
    tick();
    apply(0, 0, 0, 0, 0, 7, 7, 1, 'h03);
    chk("r31_old", rst_wen_onehot, 0);
    tick();

    // Register 0 is never claimed
    apply(0, 0, 1, 0, 'h09, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 0, 1, 'h09);
    chk("r32_wen", rst_wen_onehot, 0);
    chk("r32_pend", rst_rs_pending, 0);
    tick();

    // Fill then flush, flush beats dispatch
    for (int i = 1; i < 32; i++) begin apply(0, 0, 1, i, i, i - 1, i, 0, 0); tick(); end
    apply(0, 1, 1, 3, 'h3F, 31, 3, 0, 0); tick();
    for (int i = 0; i < 32; i++) begin
      idle(i, 31 - i);
      chk("r33_pend", rst_rs_pending, 0);
      tick();
    end
    apply(0, 0, 0, 0, 0, 3, 3, 1, 'h3F);
    chk("r33_wen", rst_wen_onehot, 0);
    tick();

    // Shared tag: reset discards, otherwise both wake
    apply(0, 0, 1, 2, 'h15, 0, 0, 0, 0); tick();
    apply(0, 0, 1, 9, 'h15, 0, 0, 0, 0); tick();
    apply(1, 0, 1, 4, 'h15, 2, 9, 1, 'h15); tick();
    apply(0, 0, 0, 0, 0, 2, 9, 1, 'h15);
    chk("r34_rst_wen", rst_wen_onehot, 0);
    tick();
    apply(0, 0, 1, 2, 'h15, 0, 0, 0, 0); tick();
    apply(0, 0, 1, 9, 'h15, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 2, 9, 1, 'h15);
    chk("r34_wen", rst_wen_onehot, 32'h204);
    tick();

    // Random traffic; narrow tag range to force sharing and collisions
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(99) == 0, $urandom_range(49) == 0, $urandom_range(9) < 6,
            int'($urandom_range(31)), int'($urandom_range(15)),
            int'($urandom_range(31)), int'($urandom_range(31)),
            $urandom_range(1) == 1, int'($urandom_range(15)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_status_table.md
REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 SHALL have parameter W_ADDR, default 5, register address width; table depth 2**W_ADDR = 32.
REQ-002 SHALL have parameter W_TAG, default 6, reservation-station/ROB tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all pending entries.
REQ-006 SHALL have port dispatch_rd_en  input  1  dispatch claims a destination register this cycle.
REQ-007 SHALL have port dispatch_rd_addr  input  W_ADDR  destination register being claimed.
REQ-008 SHALL have port dispatch_rd_tag  input  W_TAG  producer tag written into the entry.
REQ-009 SHALL have ports dispatch_rsaddr, dispatch_rtaddr  input  W_ADDR each  source lookup addresses.
REQ-010 SHALL have ports rst_rs_pending, rst_rt_pending  output  1 each  source awaits a producer.
REQ-011 SHALL have ports rst_rs_tag, rst_rt_tag  output  W_TAG each  producer tag of source.
REQ-012 SHALL have port cdb_valid  input  1  CDB broadcast valid.
REQ-013 SHALL have port cdb_tag  input  W_TAG  tag of CDB broadcast.
REQ-014 SHALL have port rst_wen_onehot  output  2**W_ADDR  one-hot regfile write enable for cdb_wdata.

Function
REQ-015 SHALL hold per register: pending bit and W_TAG tag.
REQ-016 Lookups SHALL be combinational from current state: pending/tag of addressed entry; tag output SHALL be 0 when not pending.
REQ-017 rst_wen_onehot[i] SHALL be combinational: cdb_valid & pending[i] & (tag[i]==cdb_tag); all-zero otherwise.
REQ-018 On edge with CDB match on entry i and no dispatch to i: pending[i] SHALL clear.
REQ-019 On edge with dispatch_rd_en, dispatch_rd_addr!=0: entry SHALL become pending with dispatch_rd_tag, overwriting any prior owner.
REQ-020 dispatch_rd_en with dispatch_rd_addr==0 SHALL be ignored; entry 0 never pending, wen bit 0 never asserted.
REQ-021 Dispatch and CDB match on same entry same cycle: wen bit SHALL still assert (regfile takes old value), entry SHALL end pending with new tag.
REQ-022 Multiple entries matching cdb_tag SHALL all assert wen and all clear (no priority).
REQ-023 flush SHALL clear all pending bits at the edge; flush overrides same-cycle dispatch; wen output during flush cycle unaffected.
REQ-024 Lookup of the register dispatched in the same cycle SHALL return pre-update state (no dispatch bypass).

Reset
REQ-025 reset SHALL clear all pending bits and tags to 0 at the next rising edge, overriding dispatch, CDB and flush.
REQ-026 After reset: rst_*_pending=0, rst_*_tag=0, rst_wen_onehot=0 while cdb_valid=0 or no match.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding tags; a later CDB with an old tag SHALL produce wen=0.

Configuration
REQ-028 Macro RST_CDB_BYPASS_EN: when defined, lookups SHALL report pending=0, tag=0 for an entry whose same-cycle CDB broadcast matches it (and not simultaneously re-dispatched); when undefined, lookups SHALL reflect stored state only, clearing visible the cycle after.

Verification
REQ-029 Reset, then dispatch rd=5 tag=0x11; next cycle rs=5 -> rs_pending=1, rs_tag=0x11; wen=0.
REQ-030 Entry 5 pending tag 0x11; cdb_valid=1 cdb_tag=0x11 -> wen=0x00000020 same cycle; next cycle pending[5]=0; rs lookup with macro shows pending=0 during CDB cycle, without macro pending=1.
REQ-031 Entry 7 pending tag 0x03; same cycle dispatch rd=7 tag=0x04 and CDB tag 0x03 -> wen=0x00000080; next cycle pending[7]=1 tag 0x04; later CDB 0x03 -> wen=0.
REQ-032 Dispatch rd=0 tag=0x09; CDB tag 0x09 -> entry 0 never pending, wen=0.
REQ-033 Fill entries 1..31 with tags i, assert flush with dispatch rd=3 tag=0x3F -> all pending=0 next cycle; CDB tag 0x3F -> wen=0.
REQ-034 Entries 2 and 9 both tag 0x15, reset asserted one cycle, then CDB 0x15 -> wen=0; without reset wen=0x00000204.
